// File: rtl/auto_shop_pkg.sv
// Shared types and helpers for the vending controller's BCD display path.
// Holds the sequencer state encoding, the BCD slot width and the round-robin picker.
package auto_shop_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    localparam int unsigned BCD_W = 8;

    // First set bit of req at or after ptr, wrapping modulo n (n <= 8).
    function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr,
                                           input int unsigned n);
        logic [2:0]  pick;
        logic        found;
        int unsigned idx;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            idx = (32'(ptr) + i) % n;
            if (i < n && !found && req[idx]) begin
                pick  = 3'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/bcd_serial_core.sv
// Serial double-dabble datapath: one adjust-then-shift step per enabled edge.
// Two nibbles only; operands are bounded so the tens digit never overflows.
module bcd_serial_core
    import auto_shop_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic             bit_i,
    output logic [BCD_W-1:0] value_o
);

    logic [BCD_W-1:0] value_q;
    logic [BCD_W-1:0] adj;

    always_comb begin
        adj = value_q;
        if (value_q[3:0] > 4'd4) adj[3:0] = value_q[3:0] + 4'd3;
        if (value_q[7:4] > 4'd4) adj[7:4] = value_q[7:4] + 4'd3;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else if (load_i) begin
            value_q <= '0;
        end else if (shift_i) begin
            value_q <= {adj[BCD_W-2:0], bit_i};
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/bcd_share_arbiter.sv
// Round-robin arbiter and sequencer sharing one serial binary-to-BCD core among
// NUM_REQ requesters; each result is kept in a per-channel slot for the display scan.
module bcd_share_arbiter
    import auto_shop_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned BIN_W   = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*BIN_W-1:0]   bin_in,
    output logic [NUM_REQ-1:0]         ack,
    output logic                       busy,
    output logic                       bcd_valid,
    output logic [2:0]                 bcd_id,
    output logic [7:0]                 bcd_out,
    output logic [NUM_REQ*BCD_W-1:0]   bcd_all
);

    localparam int unsigned CntW = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_num_req_chk
        $error("bcd_share_arbiter: NUM_REQ must be in 2..8");
    end
    if (BIN_W < 1 || BIN_W > 6) begin : g_bin_w_chk
        $error("bcd_share_arbiter: BIN_W must be in 1..6");
    end

    state_e                 state_q, state_d;
    logic [2:0]             id_q, id_d;
    logic [BIN_W-1:0]       opnd_q, opnd_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [2:0]             rr_ptr_q;
    logic                   core_load, core_shift;
    logic [BCD_W-1:0]       core_val;

    logic [NUM_REQ-1:0]         ack_q;
    logic                       valid_q;
    logic [2:0]                 bcd_id_q;
    logic [BCD_W-1:0]           bcd_out_q;
    logic [NUM_REQ*BCD_W-1:0]   slots_q;

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        opnd_d     = opnd_q;
        cnt_d      = cnt_q;
        core_load  = 1'b0;
        core_shift = 1'b0;
        case (state_q)
            StIdle: begin
                if (|req) begin
                    id_d      = rr_pick(8'(req), rr_ptr_q, NUM_REQ);
                    opnd_d    = bin_in[int'(id_d)*BIN_W +: BIN_W];
                    cnt_d     = CntW'(BIN_W - 1);
                    core_load = 1'b1;
                    state_d   = StShift;
                end
            end
            StShift: begin
                core_shift = 1'b1;
                if (cnt_q == '0) state_d = StDone;
                else             cnt_d   = cnt_q - 1'b1;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            id_q    <= '0;
            opnd_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            opnd_q  <= opnd_d;
            cnt_q   <= cnt_d;
        end
    end

    // Results are published on the edge leaving DONE, so ack lands in the IDLE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q  <= '0;
            ack_q     <= '0;
            valid_q   <= 1'b0;
            bcd_id_q  <= '0;
            bcd_out_q <= '0;
            slots_q   <= '0;
        end else if (state_q == StDone) begin
            ack_q     <= NUM_REQ'(1) << id_q;
            valid_q   <= 1'b1;
            bcd_id_q  <= id_q;
            bcd_out_q <= core_val;
            slots_q[int'(id_q)*BCD_W +: BCD_W] <= core_val;
            rr_ptr_q  <= (int'(id_q) == int'(NUM_REQ) - 1) ? 3'd0 : id_q + 3'd1;
        end else begin
            ack_q   <= '0;
            valid_q <= 1'b0;
        end
    end

    bcd_serial_core u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (core_load),
        .shift_i (core_shift),
        .bit_i   (opnd_q[cnt_q]),
        .value_o (core_val)
    );

    assign ack       = ack_q;
    assign busy      = (state_q != StIdle);
    assign bcd_valid = valid_q;
    assign bcd_id    = bcd_id_q;
    assign bcd_out   = bcd_out_q;
    assign bcd_all   = slots_q;

endmodule

// File: tb/tb_bcd_share_arbiter.sv
// Scoreboard bench for bcd_share_arbiter: stimulus predicts grant order and result,
// a monitor compares every cycle against the model slots and the expected queue.
module tb_bcd_share_arbiter;

    localparam int NUM = 4;
    localparam int BW  = 5;
    localparam int LAT = BW + 2;

    typedef struct {
        int         id;
        logic [7:0] val;
        int         cyc;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NUM-1:0]      req;
    logic [NUM*BW-1:0]   bin_in;
    logic [NUM-1:0]      ack;
    logic                busy;
    logic                bcd_valid;
    logic [2:0]          bcd_id;
    logic [7:0]          bcd_out;
    logic [NUM*8-1:0]    bcd_all;

    int         cyc   = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    exp_t       exp_q[$];
    logic [7:0] mdl_slot[NUM];
    logic [7:0] mdl_out;
    logic [2:0] mdl_id;
    int         ptr;
    int         opv[NUM];
    logic [NUM-1:0] hold;

    always #5 clk = ~clk;

    bcd_share_arbiter #(
        .NUM_REQ (NUM),
        .BIN_W   (BW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .bin_in    (bin_in),
        .ack       (ack),
        .busy      (busy),
        .bcd_valid (bcd_valid),
        .bcd_id    (bcd_id),
        .bcd_out   (bcd_out),
        .bcd_all   (bcd_all)
    );

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, want, cyc);
        end
    endfunction

    function automatic logic [NUM*8-1:0] packed_slots();
        logic [NUM*8-1:0] p;
        for (int i = 0; i < NUM; i++) p[i*8 +: 8] = mdl_slot[i];
        return p;
    endfunction

    // Monitor: samples 1 time unit after each rising edge.
    always begin
        exp_t e;
        @(posedge clk);
        cyc++;
        #1;
        if (!rst_n) begin
            exp_q.delete();
            for (int i = 0; i < NUM; i++) mdl_slot[i] = 8'h00;
            mdl_out = 8'h00;
            mdl_id  = 3'd0;
            chk("rst_ack", 64'(ack), 64'd0);
            chk("rst_valid", 64'(bcd_valid), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_out", 64'(bcd_out), 64'd0);
            chk("rst_id", 64'(bcd_id), 64'd0);
            chk("rst_all", 64'(bcd_all), 64'd0);
        end else begin
            if (bcd_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_ack: got id %0d val %0h ack %b, want none (cycle %0d)",
                             bcd_id, bcd_out, ack, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("ack_id", 64'(bcd_id), 64'(e.id));
                    chk("ack_value", 64'(bcd_out), 64'(e.val));
                    chk("ack_onehot", 64'(ack), 64'(NUM'(1) << e.id));
                    chk("ack_cycle", 64'(cyc), 64'(e.cyc));
                    mdl_slot[e.id] = e.val;
                    mdl_out        = e.val;
                    mdl_id         = 3'(e.id);
                end
            end else begin
                chk("ack_idle", 64'(ack), 64'd0);
                if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL missing_ack: got none, want id %0d val %0h (cycle %0d)",
                             exp_q[0].id, exp_q[0].val, cyc);
                    void'(exp_q.pop_front());
                end
            end
            chk("bcd_out_hold", 64'(bcd_out), 64'(mdl_out));
            chk("bcd_id_hold", 64'(bcd_id), 64'(mdl_id));
            chk("bcd_all", 64'(bcd_all), 64'(packed_slots()));
        end
    end

    // Requesters drop req on the negedge after seeing their ack, unless held.
    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < NUM; i++) if (ack[i] && !hold[i]) req[i] = 1'b0;
    endtask

    task automatic issue(input logic [NUM-1:0] mask);
        logic [NUM-1:0] pend;
        int t;
        int idx;
        pend = mask;
        t    = 0;
        idx  = 0;
        for (int i = 0; i < NUM; i++) if (mask[i]) bin_in[i*BW +: BW] = BW'(opv[i]);
        req = req | mask;
        while (pend != 0) begin
            for (int j = 0; j < NUM; j++) begin
                idx = (ptr + j) % NUM;
                if (pend[idx]) break;
            end
            exp_q.push_back('{id: idx, val: to_bcd(opv[idx]), cyc: cyc + LAT * (t + 1)});
            pend[idx] = 1'b0;
            ptr       = (idx + 1) % NUM;
            t++;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        hold  = '0;
        ptr   = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int n;
        rst_n  = 1'b0;
        req    = '0;
        bin_in = '0;
        hold   = '0;
        ptr    = 0;
        for (int i = 0; i < NUM; i++) opv[i] = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Single conversion, ch0 = 31
        opv[0] = 31;
        issue(4'b0001);
        drain();

        // Exhaustive sweep on ch1
        for (int v = 0; v < 32; v++) begin
            opv[1] = v;
            issue(4'b0010);
            drain();
        end

        // Four simultaneous requests from a fresh pointer
        do_reset();
        opv[0] = 7; opv[1] = 12; opv[2] = 25; opv[3] = 30;
        issue(4'b1111);
        drain();

        // ch0 and ch2 held continuously: grants alternate 0, 2, 0, 2
        hold   = 4'b0101;
        opv[0] = 5; opv[2] = 18;
        bin_in[0*BW +: BW] = BW'(opv[0]);
        bin_in[2*BW +: BW] = BW'(opv[2]);
        req = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back('{id: (k % 2) * 2, val: to_bcd(opv[(k % 2) * 2]),
                              cyc: cyc + LAT * (k + 1)});
        end
        ptr = 3;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        req  = '0;
        hold = '0;
        repeat (LAT + 3) tick();

        // Operand latched at grant; later bin_in changes ignored
        opv[0] = 17;
        issue(4'b0001);
        repeat (2) tick();
        bin_in[0*BW +: BW] = 5'd3;
        drain();

        // req dropped mid-conversion still completes
        opv[2] = 26;
        issue(4'b0100);
        repeat (3) tick();
        req[2] = 1'b0;
        drain();

        // Reset during SHIFT discards the conversion
        opv[1] = 9;
        issue(4'b0010);
        repeat (3) tick();
        do_reset();
        repeat (LAT + 2) tick();
        opv[3] = 22;
        issue(4'b1000);
        drain();

        // Randomized batches
        for (int b = 0; b < 25; b++) begin
            for (int i = 0; i < NUM; i++) opv[i] = int'($urandom_range(0, 31));
            issue(NUM'($urandom_range(1, 15)));
            drain();
        end

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
